// File: rtl/i2s_clk_ctrl_pkg.sv
// Shared types and defaults for the I2S master clock controller.
//   i2s_clk_state_t : controller FSM states
//   Def*            : default divider / frame constants
//   cnt_width()     : counter width for a modulo-n counter (at least 1 bit)
package i2s_clk_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StWarmup = 2'd1,
    StRun    = 2'd2,
    StDrain  = 2'd3
  } i2s_clk_state_t;

  localparam int unsigned DefMclkDiv   = 4;
  localparam int unsigned DefSclkDiv   = 4;
  localparam int unsigned DefBitsPerCh = 32;
  localparam int unsigned DefMclkLead  = 8;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i2s_clk_ctrl_div_cnt.sv
// Modulo-N counter with synchronous clear and increment enable.
//   clk_i      : system clock
//   rst_n      : synchronous active-low reset
//   clr_i      : force count to 0 on next edge (wins over inc_i)
//   inc_i      : advance by one, wrapping N-1 -> 0
//   cnt_o      : current count
//   cnt_next_o : value the count takes on the next edge
//   wrap_o     : inc_i while at N-1 (count wraps on the next edge)
module i2s_clk_ctrl_div_cnt
  import i2s_clk_ctrl_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned W = cnt_width(N)
) (
  input  logic         clk_i,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic [W-1:0] cnt_next_o,
  output logic         wrap_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    wrap_o = inc_i && (cnt_q == W'(N - 1));
    cnt_d  = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o      = cnt_q;
  assign cnt_next_o = cnt_d;

endmodule

// File: rtl/i2s_clk_ctrl.sv
// Master-mode I2S timing controller: derives mclk, sclk and lrck from clk and issues
// single-cycle sclk_rise / sclk_fall / frame_start strobes for the rx/tx shifters.
//   clk, rst_n  : system clock, synchronous active-low reset
//   en          : level request to run; stopping waits for the end of the current frame
//   running     : controller not idle
//   mclk/sclk   : codec master clock / bit clock
//   lrck        : word select, 0 = left, 1 = right
//   sclk_rise   : rx sample strobe; sclk_fall : tx shift strobe
//   frame_start : first cycle of the left channel
//   bit_idx     : sclk period index within the current channel
module i2s_clk_ctrl
  import i2s_clk_ctrl_pkg::*;
#(
  parameter int unsigned MCLK_DIV    = DefMclkDiv,
  parameter int unsigned SCLK_DIV    = DefSclkDiv,
  parameter int unsigned BITS_PER_CH = DefBitsPerCh,
  parameter int unsigned MCLK_LEAD   = DefMclkLead
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en,
  output logic                           running,
  output logic                           mclk,
  output logic                           sclk,
  output logic                           lrck,
  output logic                           sclk_rise,
  output logic                           sclk_fall,
  output logic                           frame_start,
  output logic [$clog2(BITS_PER_CH)-1:0] bit_idx
);

  if (MCLK_DIV < 2 || (MCLK_DIV % 2) != 0) begin : g_bad_mclk_div
    $error("MCLK_DIV must be even and >= 2");
  end
  if (SCLK_DIV < 2 || (SCLK_DIV % 2) != 0) begin : g_bad_sclk_div
    $error("SCLK_DIV must be even and >= 2");
  end
  if (BITS_PER_CH < 2) begin : g_bad_bits_per_ch
    $error("BITS_PER_CH must be >= 2");
  end
  if (MCLK_LEAD < 1) begin : g_bad_mclk_lead
    $error("MCLK_LEAD must be >= 1");
  end

  localparam int unsigned McW = cnt_width(MCLK_DIV);
  localparam int unsigned ScW = cnt_width(SCLK_DIV);
  localparam int unsigned BcW = $clog2(BITS_PER_CH);
  localparam int unsigned LdW = cnt_width(MCLK_LEAD);

  localparam logic [McW-1:0] McHalf = McW'(MCLK_DIV / 2);
  localparam logic [ScW-1:0] ScHalf = ScW'(SCLK_DIV / 2);

  i2s_clk_state_t state_q, state_d;
  logic           ch_q, ch_d;
  logic           run_d, cnt_clr, frame_last;

  logic           mc_inc, sc_inc, bc_inc, lead_inc;
  logic           mc_wrap, sc_wrap, bc_wrap, lead_wrap;
  logic [McW-1:0] mc_q, mc_d;
  logic [ScW-1:0] sc_q, sc_d;
  logic [BcW-1:0] bc_q, bc_d;
  logic [LdW-1:0] lead_q, lead_d;

  logic mclk_q, mclk_d, sclk_q, sclk_d, lrck_q, lrck_d;
  logic rise_q, rise_d, fall_q, fall_d, fs_q, fs_d;

  // Counter cascade: mc always runs outside idle; sc/bc/ch only while the link runs;
  // lead only during warm-up.
  assign mc_inc   = (state_q != StIdle);
  assign sc_inc   = ((state_q == StRun) || (state_q == StDrain)) && mc_wrap;
  assign bc_inc   = sc_wrap;
  assign lead_inc = (state_q == StWarmup) && mc_wrap;

  // Last clk cycle of the right channel: every counter is about to wrap.
  assign frame_last = ch_q && bc_wrap;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (en) state_d = StWarmup;
      end
      StWarmup: begin
        if (!en) begin
          state_d = StIdle;
        end else if (lead_wrap) begin
          state_d = StRun;
        end
      end
      StRun: begin
        // A request to stop on the final cycle of a frame has nothing left to drain.
        if (!en) state_d = frame_last ? StIdle : StDrain;
      end
      StDrain: begin
        if (en) begin
          state_d = StRun;
        end else if (frame_last) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign cnt_clr = (state_d == StIdle);
  assign ch_d    = cnt_clr ? 1'b0 : (ch_q ^ bc_wrap);

  i2s_clk_ctrl_div_cnt #(.N(MCLK_DIV), .W(McW)) u_mc_cnt (
    .clk_i(clk), .rst_n(rst_n), .clr_i(cnt_clr), .inc_i(mc_inc),
    .cnt_o(mc_q), .cnt_next_o(mc_d), .wrap_o(mc_wrap)
  );

  i2s_clk_ctrl_div_cnt #(.N(SCLK_DIV), .W(ScW)) u_sc_cnt (
    .clk_i(clk), .rst_n(rst_n), .clr_i(cnt_clr), .inc_i(sc_inc),
    .cnt_o(sc_q), .cnt_next_o(sc_d), .wrap_o(sc_wrap)
  );

  i2s_clk_ctrl_div_cnt #(.N(BITS_PER_CH), .W(BcW)) u_bc_cnt (
    .clk_i(clk), .rst_n(rst_n), .clr_i(cnt_clr), .inc_i(bc_inc),
    .cnt_o(bc_q), .cnt_next_o(bc_d), .wrap_o(bc_wrap)
  );

  i2s_clk_ctrl_div_cnt #(.N(MCLK_LEAD), .W(LdW)) u_lead_cnt (
    .clk_i(clk), .rst_n(rst_n), .clr_i(cnt_clr), .inc_i(lead_inc),
    .cnt_o(lead_q), .cnt_next_o(lead_d), .wrap_o(lead_wrap)
  );

  // Outputs are decoded from next-state counters so the registered value lines up
  // with the counter state of the same cycle.
  always_comb begin
    run_d  = (state_d == StRun) || (state_d == StDrain);
    mclk_d = (state_d != StIdle) && (mc_d >= McHalf);
    sclk_d = run_d && (sc_d >= ScHalf);
    lrck_d = run_d && ch_d;
    fall_d = run_d && (mc_d == '0) && (sc_d == '0);
    rise_d = run_d && (mc_d == '0) && (sc_d == ScHalf);
    fs_d   = fall_d && (bc_d == '0) && !ch_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ch_q    <= 1'b0;
      mclk_q  <= 1'b0;
      sclk_q  <= 1'b0;
      lrck_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      mclk_q  <= mclk_d;
      sclk_q  <= sclk_d;
      lrck_q  <= lrck_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      fs_q    <= fs_d;
    end
  end

  assign running     = (state_q != StIdle);
  assign mclk        = mclk_q;
  assign sclk        = sclk_q;
  assign lrck        = lrck_q;
  assign sclk_rise   = rise_q;
  assign sclk_fall   = fall_q;
  assign frame_start = fs_q;
  assign bit_idx     = bc_q;

  logic unused_lead;
  assign unused_lead = ^lead_q;

endmodule

// File: tb/tb_i2s_clk_ctrl.sv
// Bench for i2s_clk_ctrl: two instances (default and MCLK_DIV=2/SCLK_DIV=8/BITS_PER_CH=24)
// share clk/rst_n/en. A phase-based reference model queues the expected outputs each edge;
// they are popped and compared just after the edge, alongside timing monitors.
module tb_i2s_clk_ctrl;

  typedef struct packed {
    logic       running;
    logic       mclk;
    logic       sclk;
    logic       lrck;
    logic       rise;
    logic       fall;
    logic       fs;
    logic [7:0] bidx;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  always #5 clk = ~clk;

  logic a_running, a_mclk, a_sclk, a_lrck, a_rise, a_fall, a_fs;
  logic b_running, b_mclk, b_sclk, b_lrck, b_rise, b_fall, b_fs;
  logic [4:0] a_bidx, b_bidx;

  i2s_clk_ctrl #(.MCLK_DIV(4), .SCLK_DIV(4), .BITS_PER_CH(32), .MCLK_LEAD(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .running(a_running), .mclk(a_mclk),
    .sclk(a_sclk), .lrck(a_lrck), .sclk_rise(a_rise), .sclk_fall(a_fall),
    .frame_start(a_fs), .bit_idx(a_bidx)
  );

  i2s_clk_ctrl #(.MCLK_DIV(2), .SCLK_DIV(8), .BITS_PER_CH(24), .MCLK_LEAD(8)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .running(b_running), .mclk(b_mclk),
    .sclk(b_sclk), .lrck(b_lrck), .sclk_rise(b_rise), .sclk_fall(b_fall),
    .frame_start(b_fs), .bit_idx(b_bidx)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  exp_t sb_a[$];
  exp_t sb_b[$];

  int md[2]   = '{4, 2};
  int sd[2]   = '{4, 8};
  int bpc[2]  = '{32, 24};
  int lead[2] = '{8, 8};

  // Model state: 0 idle, 1 warm-up, 2 run, 3 drain; mt = clk phase within frame.
  int mst[2] = '{0, 0};
  int mt[2]  = '{0, 0};
  int mw[2]  = '{0, 0};

  int   prev_run[2]   = '{0, 0};
  int   prev_bidx[2]  = '{0, 0};
  int   prev_lrck[2]  = '{0, 0};
  int   rise_cyc[2]   = '{0, 0};
  int   fs_pending[2] = '{0, 0};
  int   last_fs[2]    = '{-1, -1};
  int   nrise[2]      = '{0, 0};
  int   nfall[2]      = '{0, 0};
  int   last_fs_cyc   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic model_step(input int k, input logic rn, input logic e);
    int flen;
    bit last;
    flen = 2 * bpc[k] * sd[k] * md[k];
    if (!rn) begin
      mst[k] = 0; mt[k] = 0; mw[k] = 0;
    end else begin
      case (mst[k])
        0: if (e) begin mst[k] = 1; mw[k] = 0; mt[k] = 0; end
        1: begin
          if (!e) mst[k] = 0;
          else if (mw[k] == lead[k] * md[k] - 1) begin mst[k] = 2; mt[k] = 0; end
          else mw[k]++;
        end
        default: begin
          last  = (mt[k] == flen - 1);
          mt[k] = last ? 0 : mt[k] + 1;
          if (mst[k] == 2) begin
            if (!e) mst[k] = last ? 0 : 3;
          end else if (e) begin
            mst[k] = 2;
          end else if (last) begin
            mst[k] = 0;
          end
        end
      endcase
    end
  endtask

  function automatic exp_t model_out(input int k);
    exp_t r;
    int mc, sc, bc, ch;
    r = '0;
    if (mst[k] == 0) return r;
    r.running = 1'b1;
    if (mst[k] == 1) begin
      r.mclk = ((mw[k] % md[k]) >= md[k] / 2);
      return r;
    end
    mc = mt[k] % md[k];
    sc = (mt[k] / md[k]) % sd[k];
    bc = (mt[k] / (md[k] * sd[k])) % bpc[k];
    ch = mt[k] / (md[k] * sd[k] * bpc[k]);
    r.mclk = (mc >= md[k] / 2);
    r.sclk = (sc >= sd[k] / 2);
    r.lrck = (ch == 1);
    r.fall = (mc == 0) && (sc == 0);
    r.rise = (mc == 0) && (sc == sd[k] / 2);
    r.fs   = r.fall && (bc == 0) && (ch == 0);
    r.bidx = 8'(bc);
    return r;
  endfunction

  function automatic exp_t obs(input int k);
    exp_t r;
    if (k == 0) begin
      r.running = a_running; r.mclk = a_mclk; r.sclk = a_sclk; r.lrck = a_lrck;
      r.rise = a_rise; r.fall = a_fall; r.fs = a_fs; r.bidx = 8'(a_bidx);
    end else begin
      r.running = b_running; r.mclk = b_mclk; r.sclk = b_sclk; r.lrck = b_lrck;
      r.rise = b_rise; r.fall = b_fall; r.fs = b_fs; r.bidx = 8'(b_bidx);
    end
    return r;
  endfunction

  task automatic monitor(input int k, input exp_t o);
    string nm;
    nm = (k == 0) ? "a" : "b";
    if (o.running && prev_run[k] == 0) begin
      rise_cyc[k]   = cyc;
      fs_pending[k] = 1;
    end
    if (!o.running) last_fs[k] = -1;
    if (prev_run[k] != 0 && o.running) begin
      if (int'(o.bidx) != prev_bidx[k])
        check({nm, "_bidx_step"}, 32'({o.fall, o.bidx}),
              32'({1'b1, 8'((prev_bidx[k] + 1) % bpc[k])}));
      if (int'(o.lrck) != prev_lrck[k])
        check({nm, "_lrck_edge_on_fall"}, 32'(o.fall), 32'(1));
    end
    if (o.fs) begin
      if (fs_pending[k] != 0) begin
        check({nm, "_warmup_len"}, 32'(cyc - rise_cyc[k]), 32'(lead[k] * md[k]));
        fs_pending[k] = 0;
      end else if (last_fs[k] >= 0) begin
        check({nm, "_frame_len"}, 32'(cyc - last_fs[k]), 32'(2 * bpc[k] * sd[k] * md[k]));
        check({nm, "_rises_per_frame"}, 32'(nrise[k]), 32'(2 * bpc[k]));
        check({nm, "_falls_per_frame"}, 32'(nfall[k]), 32'(2 * bpc[k]));
      end
      last_fs[k] = cyc;
      nrise[k]   = 0;
      nfall[k]   = 0;
      if (k == 0) last_fs_cyc = cyc;
    end
    nrise[k]     += int'(o.rise);
    nfall[k]     += int'(o.fall);
    prev_run[k]  = int'(o.running);
    prev_bidx[k] = int'(o.bidx);
    prev_lrck[k] = int'(o.lrck);
  endtask

  task automatic tick(input logic rn, input logic e);
    exp_t got, want;
    rst_n = rn;
    en    = e;
    @(posedge clk);
    model_step(0, rn, e);
    model_step(1, rn, e);
    sb_a.push_back(model_out(0));
    sb_b.push_back(model_out(1));
    #1;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      got = obs(k);
      if ((k == 0 && sb_a.size() == 0) || (k == 1 && sb_b.size() == 0)) begin
        check("sb_empty", 32'(0), 32'(1));
      end else begin
        want = (k == 0) ? sb_a.pop_front() : sb_b.pop_front();
        check((k == 0) ? "a_out" : "b_out", 32'(got), 32'(want));
      end
      monitor(k, got);
    end
  endtask

  initial begin
    exp_t o, prev_o;
    int   fs1;
    bit   hit;

    // Reset, then start: warm-up, first frame_start, two steady frames.
    repeat (5) tick(1'b0, 1'b0);
    repeat (33 + 2 * 1024 + 10) tick(1'b1, 1'b1);

    // Drop en at bit 5 of the left channel; the frame must run to completion.
    hit = 0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      o = obs(0);
      if (o.running && !o.lrck && o.bidx == 8'd5) hit = 1;
      else tick(1'b1, 1'b1);
    end
    check("t3_reach_bit5", 32'(hit), 32'(1));
    hit    = 0;
    prev_o = obs(0);
    for (int i = 0; i < 1100 && !hit; i++) begin
      tick(1'b1, 1'b0);
      o = obs(0);
      if (!o.running) hit = 1;
      else prev_o = o;
    end
    check("t3_reach_idle", 32'(hit), 32'(1));
    check("t3_last_bidx", 32'(prev_o.bidx), 32'(31));
    check("t3_last_lrck", 32'(prev_o.lrck), 32'(1));
    repeat (10) tick(1'b1, 1'b0);

    // Restart, then drop and re-raise en mid-frame: frame spacing must be unchanged.
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      tick(1'b1, 1'b1);
      if (obs(0).fs) hit = 1;
    end
    check("t4_first_fs", 32'(hit), 32'(1));
    fs1 = last_fs_cyc;
    repeat (200) tick(1'b1, 1'b1);
    repeat (100) tick(1'b1, 1'b0);
    hit = 0;
    for (int i = 0; i < 1100 && !hit; i++) begin
      tick(1'b1, 1'b1);
      if (obs(0).fs) hit = 1;
    end
    check("t4_next_fs", 32'(hit), 32'(1));
    check("t4_fs_spacing", 32'(last_fs_cyc - fs1), 32'(1024));

    // Reset in the right channel with en held: outputs clear, full warm-up follows.
    hit = 0;
    for (int i = 0; i < 1100 && !hit; i++) begin
      tick(1'b1, 1'b1);
      if (obs(0).lrck) hit = 1;
    end
    check("t5_reach_right", 32'(hit), 32'(1));
    tick(1'b0, 1'b1);
    check("t5_reset_outputs", 32'(obs(0)), 32'(0));
    repeat (1100) tick(1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
